// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op/state encodings and special-result constants for mul_div_unit
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Replicated to N bits: divide-by-zero quotient is all ones, overflow remainder is all zeros,
  // overflow quotient is the most-negative value (MSB set, rest cleared).
  localparam logic MDU_DIV0_FILL    = 1'b1;
  localparam logic MDU_OVF_REM_FILL = 1'b0;
  localparam logic MDU_OVF_QUOT_MSB = 1'b1;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate (operand magnitude / result sign fix-up)
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle.
// Define MDU_EARLY_OUT_EN to finish trivial operations one edge after acceptance.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter  int N     = 32,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  localparam logic [N-1:0] MOST_NEG = {MDU_OVF_QUOT_MSB, {(N-1){1'b0}}};

  mdu_state_e state, state_nx;

  logic [2:0]       op_q;
  logic [N-1:0]     m_q, hi, lo, hi_nx, lo_nx;
  logic             neg_q, div0_q, ovf_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, finish;

  logic             a_signed, b_signed, a_neg, b_neg, neg_in, div0_in, ovf_in;
  logic [N-1:0]     a_mag, b_mag;
  logic [N:0]       sum, shifted, diff;
  logic [2*N-1:0]   prod_fix;
  logic [N-1:0]     div_sel, div_fix, result;
  logic             early_hit;
  logic [N-1:0]     early_res;

  // Operand preparation: signedness per funct3, then magnitudes.
  assign a_signed = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  assign b_signed = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  assign a_neg    = a_signed & inA[N-1];
  assign b_neg    = b_signed & inB[N-1];
  assign neg_in   = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
  assign div0_in  = op[2] & (inB == '0);
  assign ovf_in   = op[2] & ~op[0] & (inA == MOST_NEG) & (&inB);

  mdu_sign_fix #(.W(N)) u_mag_a (.value(inA), .negate(a_neg), .result(a_mag));
  mdu_sign_fix #(.W(N)) u_mag_b (.value(inB), .negate(b_neg), .result(b_mag));

`ifdef MDU_EARLY_OUT_EN
  logic mul_zero, ult;
  assign mul_zero = ~op[2] & ((inA == '0) | (inB == '0));
  assign ult      = op[2] & op[0] & (inA < inB);
  assign early_hit = mul_zero | div0_in | ovf_in | ult;

  always_comb begin
    early_res = '0;
    if (div0_in)     early_res = op[1] ? inA : {N{MDU_DIV0_FILL}};
    else if (ovf_in) early_res = op[1] ? {N{MDU_OVF_REM_FILL}} : MOST_NEG;
    else if (ult)    early_res = op[1] ? inA : '0;
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
    shifted = {hi, lo[N-1]};
    diff    = shifted - {1'b0, m_q};
    if (!op_q[2]) begin
      hi_nx = sum[N:1];
      lo_nx = {sum[0], lo[N-1:1]};
    end else if (!diff[N]) begin
      hi_nx = diff[N-1:0];
      lo_nx = {lo[N-2:0], 1'b1};
    end else begin
      hi_nx = shifted[N-1:0];
      lo_nx = {lo[N-2:0], 1'b0};
    end
  end

  assign div_sel = op_q[1] ? hi_nx : lo_nx;

  mdu_sign_fix #(.W(2*N)) u_fix_prod (.value({hi_nx, lo_nx}), .negate(neg_q), .result(prod_fix));
  mdu_sign_fix #(.W(N))   u_fix_div  (.value(div_sel),        .negate(neg_q), .result(div_fix));

  always_comb begin
    result = div_fix;
    if (!op_q[2])                result = (op_q[1:0] == 2'b00) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
    else if (div0_q && !op_q[1]) result = {N{MDU_DIV0_FILL}};
    else if (ovf_q)              result = op_q[1] ? {N{MDU_OVF_REM_FILL}} : MOST_NEG;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      MDU_IDLE: if (!flush && in_valid) begin
        accept   = 1'b1;
        state_nx = early_hit ? MDU_DONE : MDU_BUSY;
      end
      MDU_BUSY: if (flush) state_nx = MDU_IDLE;
        else if (cnt == CNT_W'(1)) begin
          finish   = 1'b1;
          state_nx = MDU_DONE;
        end
      MDU_DONE: if (flush || out_ready) state_nx = MDU_IDLE;
      default:  state_nx = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= MDU_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      m_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
      out    <= '0;
    end else if (accept) begin
      op_q   <= op;
      m_q    <= op[2] ? b_mag : a_mag;
      lo     <= op[2] ? a_mag : b_mag;
      hi     <= '0;
      neg_q  <= neg_in;
      div0_q <= div0_in;
      ovf_q  <= ovf_in;
      cnt    <= CNT_W'(N);
      if (early_hit) out <= early_res;
    end else if (state == MDU_BUSY && !flush) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt - CNT_W'(1);
      if (finish) out <= result;
    end
  end

  assign in_ready  = (state == MDU_IDLE);
  assign out_valid = (state == MDU_DONE);
  assign busy      = (state != MDU_IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit (honours MDU_EARLY_OUT_EN latency)
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] inA = 32'd0;
  logic [31:0] inB = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  mul_div_unit dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .inA(inA), .inB(inB),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    r  = 32'd0;
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      default: begin
        if (b == 32'd0)                                            r = o[1] ? a : 32'hFFFF_FFFF;
        else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = o[1] ? 32'd0 : 32'h8000_0000;
        else if (o == 3'd4)                                        r = sa / sb;
        else if (o == 3'd5)                                        r = a / b;
        else if (o == 3'd6)                                        r = sa % sb;
        else                                                       r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit early;
    early = 1'b0;
    if (!o[2])                                                   early = (a == 32'd0) || (b == 32'd0);
    else if (b == 32'd0)                                         early = 1'b1;
    else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)  early = 1'b1;
    else if (o[0] && a < b)                                      early = 1'b1;
`ifdef MDU_EARLY_OUT_EN
    return early ? 1 : 32;
`else
    return early ? 32 : 32;
`endif
  endfunction

  // Drives one request at mid-cycle; after the accepting edge the inputs are scrambled.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
    op = o; inA = a; inB = b; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    op  = ~o;
    inA = ~a;
    inB = $urandom;
  endtask

  task automatic collect(input string tag, input int lat, input bit handoff);
    int          cnt;
    bit          rdy_seen;
    logic [31:0] want;
    cnt = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cnt < 200) begin
      @(posedge clock); #1;
      cnt++;
      if (in_ready) rdy_seen = 1'b1;
    end
    check_eq({tag, "_lat"}, 32'(cnt), 32'(lat));
    check_eq({tag, "_inrdy"}, {31'd0, rdy_seen}, 32'd0);
    check_eq({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check_eq(tag, out, want);
    end
    if (handoff) begin
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check_eq({tag, "_ho"}, {29'd0, busy, out_valid, in_ready}, 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want);
    exp_q.push_back(want);
    start_op(o, a, b);
    collect(tag, exp_lat(o, a, b), 1'b1);
  endtask

  initial begin
    logic [31:0] held;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;

    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out", out, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;

    run_op("mul",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu",    3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div",      3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA);
    run_op("rem",      3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE);
    run_op("divu",     3'd5, 32'd100,       32'd7,         32'd14);
    run_op("remu",     3'd7, 32'd100,       32'd7,         32'd2);
    run_op("divu_z",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("rem_z",    3'd6, 32'd5,         32'd0,         32'd5);
    run_op("div_nz",   3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_op("rem_nz",   3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("mul_zero", 3'd0, 32'd0,         32'd5,         32'd0);
    run_op("divu_lt",  3'd5, 32'd3,         32'd10,        32'd0);
    run_op("remu_lt",  3'd7, 32'd3,         32'd10,        32'd3);

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    // Backpressure, then a request waiting across the handoff edge.
    exp_q.push_back(32'd15);
    start_op(3'd0, 32'd3, 32'd5);
    collect("bp", 32, 1'b0);
    held = out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check_eq("bp_hold", out, held);
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_inrdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd5; inA = 32'd100; inB = 32'd7;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check_eq("bp_release", {29'd0, out_valid, in_ready, busy}, 32'd2);
    run_op("b2b", 3'd5, 32'd100, 32'd7, 32'd14);

    // Flush during iteration 10.
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check_eq("flush_idle", {29'd0, busy, out_valid, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush_no_valid", {31'd0, seen}, 32'd0);

    flush = 1'b1; in_valid = 1'b1; op = 3'd0; inA = 32'd2; inB = 32'd3;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_blocks_accept", {31'd0, busy}, 32'd0);
    run_op("flush_next", 3'd5, 32'd9, 32'd2, 32'd4);

    // Asynchronous reset in the middle of BUSY.
    start_op(3'd0, 32'd7, 32'd9);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_eq("rst_mid_state", {29'd0, busy, out_valid, in_ready}, 32'd1);
    check_eq("rst_mid_out", out, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_op("post_rst", 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative, parametrised multiply/divide unit implementing the RV32M operations; the sequential companion to the single-cycle execute ALU.
- Sits beside the ALU in the EX stage and stalls the pipeline through a valid/ready handshake.
- Processes one bit per cycle for both multiply (shift-add) and divide (restoring).
- Produces a single N-bit result per accepted operation.

Parameters:
- N, 32, operand and result width; must be ≥ 4.
- CNT_W, $clog2(N)+1, iteration-counter width; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of any in-flight operation (branch mispredict or exception).
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- inA  in  N  rs1 operand (multiplicand or dividend).
- inB  in  N  rs2 operand (multiplier or divisor).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out  out  N  result.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - out_valid=0, out=0, busy=0, in_ready=1.
  - Counter and datapath registers cleared.
- State machine IDLE/BUSY/DONE:
  - IDLE: if in_valid, latch op and operands, take operand magnitudes for signed ops, record result sign, load counter=N, go to BUSY.
  - BUSY: one iteration per cycle, counter decrements. The edge that completes the last iteration applies the sign fix-up, registers out, sets out_valid=1 and moves to DONE.
  - DONE: hold out and out_valid stable until out_ready=1, then return to IDLE (out_valid=0 on the next cycle).
  - No new request is accepted in the same cycle as the result handoff.
- Latency:
  - out_valid rises exactly N clock edges after the accepting edge.
  - Latency is independent of operand values.
  - Throughput is one operation per N+2 cycles with out_ready held high.
- Multiply:
  - 2N-bit product accumulated from operand magnitudes.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Final negate when the result sign is 1.
  - MUL returns the low N bits; MULH/MULHSU/MULHU return the high N bits.
- Divide, restoring, on magnitudes:
  - DIV/REM signed, DIVU/REMU unsigned.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Boundary conditions:
  - Divide by zero: quotient all ones (0xFFFFFFFF for N=32); remainder = inA, for both signed and unsigned.
  - Signed overflow (inA = most-negative, inB = −1): DIV returns most-negative; REM returns 0.
  - Both special cases still take the full N cycles.
- flush:
  - Flush in BUSY or DONE returns to IDLE on the next edge with out_valid=0; the result is discarded.
  - Flush in IDLE blocks acceptance that cycle.
  - Flush has priority over in_valid and out_ready.
- Changes to in_valid/op/operands while BUSY are ignored.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- When defined, these cases skip BUSY and go IDLE→DONE in one cycle (out_valid one edge after acceptance):
  - divide by zero;
  - signed DIV/REM overflow;
  - multiply with either operand zero;
  - unsigned divide with inA < inB (quotient 0, remainder inA).
- Result values are identical to the iterative path.
- When undefined, latency is always N.

Decomposition:
- Shared constants package:
  - op encodings (MDU_MUL…MDU_REMU);
  - state encoding (MDU_IDLE, MDU_BUSY, MDU_DONE);
  - helper constants for the divide-by-zero and overflow results.
- One natural sub-module, mdu_sign_fix: combinational magnitude/negate helper, instantiated for operand preparation and result fix-up.
- Control FSM and datapath stay in mul_div_unit.

Test Plan:
- MUL inA=7, inB=−3 (0xFFFFFFFD) -> out=0xFFFFFFEB after exactly 32 edges; in_ready low throughout.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −20/3 -> 0xFFFFFFFA (−6); REM −20/3 -> 0xFFFFFFFE (−2); DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; with MDU_EARLY_OUT_EN each case ready after 1 edge.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out stable and in_ready=0; out_ready=1 -> IDLE next cycle; a back-to-back request is accepted the following cycle.
- flush at iteration 10 -> IDLE next edge, no out_valid; a new DIVU 9/2 then yields 4. reset pulsed mid-BUSY -> immediate IDLE, out=0.
